// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Accepts one ALU command at a time and serialises it onto the byte-wide
// math-unit bus: an opcode byte marked with ctl=1, followed by the operand
// bytes the opcode needs (MSB first, ctl=0).  It then waits for the math unit
// to pulse ready with a result, bounded by TIMEOUT_CYC cycles.  It presents
// the result, or an error, on a valid/ready response port.
//
// Ports
//   clk        : clock; all flops update on the rising edge
//   rst_n      : asynchronous active-low reset
//   cmd_valid  : command request
//   cmd_ready  : sequencer is idle and can accept a command
//   cmd_op     : opcode (0..9 legal, 10..15 illegal)
//   cmd_a      : operand A
//   cmd_b      : operand B
//   ctl        : math-unit framing, high only while dat carries the opcode
//   dat        : math-unit byte (opcode or operand byte)
//   result     : math-unit result, valid while ready=1
//   ready      : math-unit one-cycle result strobe
//   rsp_valid  : response available
//   rsp_ready  : response consumer accepts
//   rsp_data   : captured result (0 on error)
//   rsp_err    : 1 = illegal opcode or timeout
// ---------------------------------------------------------------------------
module alu_cmd_sequencer #(
   parameter int unsigned TIMEOUT_CYC = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_op,
   input  logic [15:0] cmd_a,
   input  logic [15:0] cmd_b,
   output logic        ctl,
   output logic [7:0]  dat,
   input  logic [31:0] result,
   input  logic        ready,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err
);

   typedef enum logic [2:0] {
      IDLE,
      SEND_OP,
      SEND_AM,
      SEND_AL,
      SEND_BM,
      SEND_BL,
      WAIT,
      RESP
   } state_t;

   localparam logic [3:0] OP_INC_A   = 4'd6;
   localparam logic [3:0] OP_INC_B   = 4'd7;
   localparam logic [3:0] OP_CLR_RES = 4'd8;
   localparam logic [3:0] OP_ACCUM   = 4'd9;
   localparam logic [3:0] OP_LAST    = 4'd9;

   // WAIT cycles are numbered from 1; the counter holds (cycle number - 1),
   // so the last allowed cycle is the one where the counter reads TIMEOUT_CYC-1.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

   state_t      state_reg, state_next;
   logic [3:0]  op_reg, op_next;
   logic [15:0] a_reg, a_next;
   logic [15:0] b_reg, b_next;
   logic [7:0]  cnt_reg, cnt_next;

   // All externally visible outputs come straight from these flops.
   logic        cmd_ready_reg, cmd_ready_next;
   logic        ctl_reg, ctl_next;
   logic [7:0]  dat_reg, dat_next;
   logic        rsp_valid_reg, rsp_valid_next;
   logic [31:0] rsp_data_reg, rsp_data_next;
   logic        rsp_err_reg, rsp_err_next;

   assign cmd_ready = cmd_ready_reg;
   assign ctl       = ctl_reg;
   assign dat       = dat_reg;
   assign rsp_valid = rsp_valid_reg;
   assign rsp_data  = rsp_data_reg;
   assign rsp_err   = rsp_err_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         op_reg        <= 4'h0;
         a_reg         <= 16'h0000;
         b_reg         <= 16'h0000;
         cnt_reg       <= 8'h00;
         cmd_ready_reg <= 1'b0;
         ctl_reg       <= 1'b0;
         dat_reg       <= 8'h00;
         rsp_valid_reg <= 1'b0;
         rsp_data_reg  <= 32'h0000_0000;
         rsp_err_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         op_reg        <= op_next;
         a_reg         <= a_next;
         b_reg         <= b_next;
         cnt_reg       <= cnt_next;
         cmd_ready_reg <= cmd_ready_next;
         ctl_reg       <= ctl_next;
         dat_reg       <= dat_next;
         rsp_valid_reg <= rsp_valid_next;
         rsp_data_reg  <= rsp_data_next;
         rsp_err_reg   <= rsp_err_next;
      end
   end

   // Next-state logic.  The output flops are loaded with the values that
   // belong to the state being entered, so they line up with state_reg.
   always_comb begin
      state_next     = state_reg;
      op_next        = op_reg;
      a_next         = a_reg;
      b_next         = b_reg;
      cnt_next       = cnt_reg;
      cmd_ready_next = 1'b0;
      ctl_next       = 1'b0;
      dat_next       = 8'h00;
      rsp_valid_next = rsp_valid_reg;
      rsp_data_next  = rsp_data_reg;
      rsp_err_next   = rsp_err_reg;

      case (state_reg)
         IDLE: begin
            cmd_ready_next = 1'b1;
            // cmd_ready_reg is low for the first cycle after reset release,
            // so the handshake must qualify on the flop, not on the state.
            if (cmd_valid && cmd_ready_reg) begin
               cmd_ready_next = 1'b0;
               op_next        = cmd_op;
               a_next         = cmd_a;
               b_next         = cmd_b;
               if (cmd_op <= OP_LAST) begin
                  state_next = SEND_OP;
                  ctl_next   = 1'b1;
                  dat_next   = {4'h0, cmd_op};
               end else begin
                  // Illegal opcode: nothing reaches the math unit.
                  state_next     = RESP;
                  rsp_valid_next = 1'b1;
                  rsp_data_next  = 32'h0000_0000;
                  rsp_err_next   = 1'b1;
               end
            end
         end

         SEND_OP: begin
            if (op_reg == OP_CLR_RES) begin
               state_next = WAIT;
               cnt_next   = 8'h00;
            end else if (op_reg == OP_INC_B) begin
               state_next = SEND_BM;
               dat_next   = b_reg[15:8];
            end else begin
               state_next = SEND_AM;
               dat_next   = a_reg[15:8];
            end
         end

         SEND_AM: begin
            state_next = SEND_AL;
            dat_next   = a_reg[7:0];
         end

         SEND_AL: begin
            // INC_A and ACCUM only carry operand A.
            if (op_reg == OP_INC_A || op_reg == OP_ACCUM) begin
               state_next = WAIT;
               cnt_next   = 8'h00;
            end else begin
               state_next = SEND_BM;
               dat_next   = b_reg[15:8];
            end
         end

         SEND_BM: begin
            state_next = SEND_BL;
            dat_next   = b_reg[7:0];
         end

         SEND_BL: begin
            state_next = WAIT;
            cnt_next   = 8'h00;
         end

         WAIT: begin
            // A ready strobe in the final allowed cycle still beats the timeout.
            if (ready) begin
               state_next     = RESP;
               rsp_valid_next = 1'b1;
               rsp_data_next  = result;
               rsp_err_next   = 1'b0;
            end else if (cnt_reg == CNT_LAST) begin
               state_next     = RESP;
               rsp_valid_next = 1'b1;
               rsp_data_next  = 32'h0000_0000;
               rsp_err_next   = 1'b1;
            end else begin
               cnt_next = cnt_reg + 8'd1;
            end
         end

         RESP: begin
            if (rsp_valid_reg && rsp_ready) begin
               state_next     = IDLE;
               rsp_valid_next = 1'b0;
               cmd_ready_next = 1'b1;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule
